// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared opcodes, mux encodings, ALU operators and FSM states for bip_control
package bip_pkg;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  localparam logic ALU_ADD = 1'b1;
  localparam logic ALU_SUB = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/bip_decoder.sv
// rtl/bip_decoder.sv - combinational opcode to control-bundle decode
module bip_decoder
  import bip_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [1:0] sel_a,
  output logic       sel_b,
  output logic       alu_op,
  output logic       wr_acc,
  output logic       wr_ram,
  output logic       rd_ram,
  output logic       is_hlt
);

  always_comb begin
    sel_a  = SEL_A_RAM;
    sel_b  = 1'b0;
    alu_op = ALU_ADD;
    wr_acc = 1'b0;
    wr_ram = 1'b0;
    rd_ram = 1'b0;
    is_hlt = 1'b0;
    case (opcode)
      OPC_HLT: is_hlt = 1'b1;
      OPC_STO: wr_ram = 1'b1;
      OPC_LD: begin
        rd_ram = 1'b1;
        wr_acc = 1'b1;
      end
      OPC_LDI: begin
        sel_a  = SEL_A_IMM;
        wr_acc = 1'b1;
      end
      OPC_ADD, OPC_SUB: begin
        rd_ram = 1'b1;
        sel_a  = SEL_A_ALU;
        wr_acc = 1'b1;
        alu_op = (opcode == OPC_ADD) ? ALU_ADD : ALU_SUB;
      end
      OPC_ADDI, OPC_SUBI: begin
        sel_b  = 1'b1;
        sel_a  = SEL_A_ALU;
        wr_acc = 1'b1;
        alu_op = (opcode == OPC_ADDI) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// rtl/bip_control.sv - fetch/exec sequencer driving the accumulator datapath
// Optional busy-cycle counter port enabled by BIP_CYCLE_COUNT_EN.
module bip_control
  import bip_pkg::*;
#(
  parameter int N_BITS   = 16,
  parameter int PC_BITS  = 11,
  parameter int OPC_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_BITS-1:0]   instr,
  output logic [PC_BITS-1:0]  pc,
  output logic [PC_BITS-1:0]  data_addr,
  output logic [N_BITS-1:0]   imm,
  output logic [1:0]          sel_a,
  output logic                sel_b,
  output logic                alu_op,
  output logic                wr_acc,
  output logic                wr_ram,
  output logic                rd_ram,
  output logic                busy,
  output logic                halted
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [31:0]         cycle_count
`endif
);

  state_e               state_q, state_d;
  logic [PC_BITS-1:0]   pc_q, pc_d;
  logic                 start_acc;

  logic [1:0] dec_sel_a;
  logic       dec_sel_b, dec_alu_op, dec_wr_acc, dec_wr_ram, dec_rd_ram, dec_is_hlt;

  bip_decoder u_decoder (
    .opcode (instr[N_BITS-1 -: OPC_BITS]),
    .sel_a  (dec_sel_a),
    .sel_b  (dec_sel_b),
    .alu_op (dec_alu_op),
    .wr_acc (dec_wr_acc),
    .wr_ram (dec_wr_ram),
    .rd_ram (dec_rd_ram),
    .is_hlt (dec_is_hlt)
  );

  assign pc        = pc_q;
  assign data_addr = instr[PC_BITS-1:0];
  assign imm       = {{(N_BITS-PC_BITS){instr[PC_BITS-1]}}, instr[PC_BITS-1:0]};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    start_acc = 1'b0;
    sel_a     = SEL_A_RAM;
    sel_b     = 1'b0;
    alu_op    = 1'b0;
    wr_acc    = 1'b0;
    wr_ram    = 1'b0;
    rd_ram    = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_IDLE: start_acc = start;
      ST_FETCH: begin
        busy    = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // Decoded controls are only exposed here, so nothing leaks across instructions.
        busy   = 1'b1;
        sel_a  = dec_sel_a;
        sel_b  = dec_sel_b;
        alu_op = dec_alu_op;
        wr_acc = dec_wr_acc;
        wr_ram = dec_wr_ram;
        rd_ram = dec_rd_ram;
        if (dec_is_hlt) begin
          state_d = ST_HALTED;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
        halted    = 1'b1;
        start_acc = start;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_acc) begin
      pc_d    = '0;
      state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_acc) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_bip_control.sv
// tb/tb_bip_control.sv - directed self-checking bench for bip_control
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;
  logic [10:0] pc;
  logic [10:0] data_addr;
  logic [15:0] imm;
  logic [1:0]  sel_a;
  logic        sel_b, alu_op, wr_acc, wr_ram, rd_ram, busy, halted;
`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] rom [0:2047];

  // control vector: {sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram, busy, halted}
  localparam logic [8:0] C_IDLE  = 9'b00_0_0_000_0_0;
  localparam logic [8:0] C_FETCH = 9'b00_0_0_000_1_0;
  localparam logic [8:0] C_HALT  = 9'b00_0_0_000_0_1;
  localparam logic [8:0] C_NOPX  = 9'b00_0_1_000_1_0;
  localparam logic [8:0] C_LDI   = 9'b01_0_1_100_1_0;
  localparam logic [8:0] C_ADDI  = 9'b10_1_1_100_1_0;
  localparam logic [8:0] C_SUBI  = 9'b10_1_0_100_1_0;
  localparam logic [8:0] C_STO   = 9'b00_0_1_010_1_0;
  localparam logic [8:0] C_LD    = 9'b00_0_1_101_1_0;
  localparam logic [8:0] C_ADD   = 9'b10_0_1_101_1_0;

  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[pc];

  bip_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (instr),
    .pc        (pc),
    .data_addr (data_addr),
    .imm       (imm),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .alu_op    (alu_op),
    .wr_acc    (wr_acc),
    .wr_ram    (wr_ram),
    .rd_ram    (rd_ram),
    .busy      (busy),
    .halted    (halted)
`ifdef BIP_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  function automatic logic [8:0] ctl();
    return {sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram, busy, halted};
  endfunction

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 2048; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge of the first FETCH cycle.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_rom(16'h0000);
    do_reset();
    tests_run++;
    if (ctl() !== C_IDLE) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b want %b", ctl(), C_IDLE);
    end
    tests_run++;
    if (pc !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_pc: got %0d want 0", pc);
    end
  endtask

  task automatic test_basic();
    fill_rom(16'h0000);
    rom[0] = {5'b00011, 11'd5};
    rom[1] = {5'b00101, 11'd3};
    do_reset();
    pulse_start();
    tests_run++;
    if (ctl() !== C_FETCH || pc !== 11'd0) begin
      tests_failed++;
      $display("FAIL basic_fetch0: got ctl %b pc %0d want %b pc 0", ctl(), pc, C_FETCH);
    end
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_LDI || imm !== 16'd5) begin
      tests_failed++;
      $display("FAIL basic_ldi: got ctl %b imm %h want %b imm 0005", ctl(), imm, C_LDI);
    end
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_FETCH || pc !== 11'd1) begin
      tests_failed++;
      $display("FAIL basic_fetch1: got ctl %b pc %0d want %b pc 1", ctl(), pc, C_FETCH);
    end
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_ADDI || imm !== 16'd3) begin
      tests_failed++;
      $display("FAIL basic_addi: got ctl %b imm %h want %b imm 0003", ctl(), imm, C_ADDI);
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_NOPX || pc !== 11'd2) begin
      tests_failed++;
      $display("FAIL basic_hlt_exec: got ctl %b pc %0d want %b pc 2", ctl(), pc, C_NOPX);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (ctl() !== C_HALT || pc !== 11'd2) begin
        tests_failed++;
        $display("FAIL basic_halted%0d: got ctl %b pc %0d want %b pc 2", i, ctl(), pc, C_HALT);
      end
    end
  endtask

  task automatic test_subi();
    fill_rom(16'h0000);
    rom[0] = {5'b00111, 11'h7FF};
    do_reset();
    pulse_start();
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_SUBI || imm !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL subi: got ctl %b imm %h want %b imm ffff", ctl(), imm, C_SUBI);
    end
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_FETCH) begin
      tests_failed++;
      $display("FAIL subi_one_cycle: got ctl %b want %b", ctl(), C_FETCH);
    end
  endtask

  task automatic test_sto_ld();
    fill_rom(16'h0000);
    rom[0] = {5'b00001, 11'h123};
    rom[1] = {5'b00010, 11'h123};
    do_reset();
    pulse_start();
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_STO || data_addr !== 11'h123) begin
      tests_failed++;
      $display("FAIL sto: got ctl %b addr %h want %b addr 123", ctl(), data_addr, C_STO);
    end
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_FETCH) begin
      tests_failed++;
      $display("FAIL sto_ld_gap: got ctl %b want %b", ctl(), C_FETCH);
    end
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_LD || data_addr !== 11'h123) begin
      tests_failed++;
      $display("FAIL ld: got ctl %b addr %h want %b addr 123", ctl(), data_addr, C_LD);
    end
  endtask

  task automatic test_wrap();
    logic found;
    found = 1'b0;
    fill_rom({5'b11111, 11'h055});
    do_reset();
    pulse_start();
    for (int i = 0; i < 4200 && !found; i++) begin
      @(negedge clk);
      if (pc == 11'd2047 && ctl() == C_NOPX) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL wrap_reach: got no EXEC at pc 2047 within budget, want one");
    end
    rom[1] = 16'h0000;
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_FETCH || pc !== 11'd0) begin
      tests_failed++;
      $display("FAIL wrap_pc: got ctl %b pc %0d want %b pc 0", ctl(), pc, C_FETCH);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (ctl() !== C_HALT || pc !== 11'd1) begin
      tests_failed++;
      $display("FAIL wrap_continue: got ctl %b pc %0d want %b pc 1", ctl(), pc, C_HALT);
    end
  endtask

  task automatic test_reset_mid();
    fill_rom(16'h0000);
    rom[0] = {5'b00011, 11'd1};
    rom[1] = {5'b00100, 11'h010};
    do_reset();
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (ctl() !== C_ADD || pc !== 11'd1) begin
      tests_failed++;
      $display("FAIL start_in_fetch: got ctl %b pc %0d want %b pc 1", ctl(), pc, C_ADD);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (ctl() !== C_IDLE || pc !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_exec: got ctl %b pc %0d want %b pc 0", ctl(), pc, C_IDLE);
    end
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_IDLE) begin
      tests_failed++;
      $display("FAIL reset_mid_stays_idle: got ctl %b want %b", ctl(), C_IDLE);
    end
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_IDLE) begin
      tests_failed++;
      $display("FAIL reset_beats_start: got ctl %b want %b", ctl(), C_IDLE);
    end
  endtask

  task automatic test_restart();
    fill_rom(16'h0000);
    rom[0] = {5'b00011, 11'd7};
    do_reset();
    pulse_start();
    repeat (4) @(negedge clk);
    tests_run++;
    if (ctl() !== C_HALT || pc !== 11'd1) begin
      tests_failed++;
      $display("FAIL restart_first_halt: got ctl %b pc %0d want %b pc 1", ctl(), pc, C_HALT);
    end
`ifdef BIP_CYCLE_COUNT_EN
    tests_run++;
    if (cycle_count !== 32'd4) begin
      tests_failed++;
      $display("FAIL count_at_halt: got %0d want 4", cycle_count);
    end
    @(negedge clk);
    tests_run++;
    if (cycle_count !== 32'd4) begin
      tests_failed++;
      $display("FAIL count_held: got %0d want 4", cycle_count);
    end
`endif
    pulse_start();
    tests_run++;
    if (ctl() !== C_FETCH || pc !== 11'd0) begin
      tests_failed++;
      $display("FAIL restart_fetch: got ctl %b pc %0d want %b pc 0", ctl(), pc, C_FETCH);
    end
`ifdef BIP_CYCLE_COUNT_EN
    tests_run++;
    if (cycle_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL count_cleared: got %0d want 0", cycle_count);
    end
`endif
    @(negedge clk);
    tests_run++;
    if (ctl() !== C_LDI || imm !== 16'd7) begin
      tests_failed++;
      $display("FAIL restart_ldi: got ctl %b imm %h want %b imm 0007", ctl(), imm, C_LDI);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_basic();
    test_subi();
    test_sto_ld();
    test_wrap();
    test_reset_mid();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
